// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
// The master side issues requests and the slave side returns responses.
interface fetch_ifid_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_ifid_stage.sv
// RV32I instruction-fetch stage with IF/ID register, one outstanding request and a 1-entry skid.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_ifid_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_enable,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  fetch_ifid_stage_if.master  imem,
  output logic                valid_IFID,
  output logic [XLEN-1:0]     pc_IFID,
  output logic [31:0]         inst_IFID,
  output logic [4:0]          rs1_IFID,
  output logic [4:0]          rs2_IFID,
  output logic [4:0]          rd_IFID
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic            kill_r, kill_s;
  logic [XLEN-1:0] skid_pc_r, skid_pc_s;
  logic [31:0]     skid_inst_r, skid_inst_s;
  logic            valid_s;
  logic [XLEN-1:0] pc_ifid_s;
  logic [31:0]     inst_ifid_s;
  logic [XLEN-1:0] pc_inc_s;
  logic [XLEN-1:0] redirect_target_s;

  assign pc_inc_s          = pc_r + {{(XLEN-3){1'b0}}, 3'b100};
  assign redirect_target_s = redirect_pc & {{(XLEN-1){1'b1}}, 1'b0};

  assign imem.imem_req  = (state_r == S_IDLE) && !redirect_valid && !rst;
  assign imem.imem_addr = pc_r;

  assign rs1_IFID = inst_IFID[19:15];
  assign rs2_IFID = inst_IFID[24:20];
  assign rd_IFID  = inst_IFID[11:7];

  // Next-state, PC, skid and IF/ID selection; redirect overrides stall and every transition.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    kill_s      = kill_r;
    skid_pc_s   = skid_pc_r;
    skid_inst_s = skid_inst_r;
    valid_s     = valid_IFID;
    pc_ifid_s   = pc_IFID;
    inst_ifid_s = inst_IFID;

    // An enabled cycle that delivers nothing leaves a bubble behind.
    if (pc_enable) begin
      valid_s     = 1'b0;
      inst_ifid_s = NOP_INST;
    end else begin
      valid_s     = valid_IFID;
      inst_ifid_s = inst_IFID;
    end

    if (redirect_valid) begin
      valid_s     = 1'b0;
      inst_ifid_s = NOP_INST;
      pc_s        = redirect_target_s;
      case (state_r)
        S_IDLE: begin
          state_s = S_IDLE;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            state_s = S_IDLE;
            kill_s  = 1'b0;
          end else begin
            kill_s  = 1'b1;
          end
        end
        S_HOLD: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
          kill_s  = 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        S_IDLE: begin
          state_s = S_WAIT;
        end
        S_WAIT: begin
          if (!imem.imem_rvalid) begin
            state_s = S_WAIT;
          end else if (kill_r) begin
            kill_s  = 1'b0;
            state_s = S_IDLE;
          end else if (pc_enable) begin
            valid_s     = 1'b1;
            pc_ifid_s   = pc_r;
            inst_ifid_s = imem.imem_rdata;
            pc_s        = pc_inc_s;
            state_s     = S_IDLE;
          end else begin
            skid_pc_s   = pc_r;
            skid_inst_s = imem.imem_rdata;
            state_s     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (pc_enable) begin
            valid_s     = 1'b1;
            pc_ifid_s   = skid_pc_r;
            inst_ifid_s = skid_inst_r;
            pc_s        = pc_inc_s;
            state_s     = S_IDLE;
          end else begin
            state_s = S_HOLD;
          end
        end
        default: begin
          state_s = S_IDLE;
          kill_s  = 1'b0;
        end
      endcase
    end
  end

  // State, PC, skid and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      kill_r      <= 1'b0;
      skid_pc_r   <= {XLEN{1'b0}};
      skid_inst_r <= NOP_INST;
      valid_IFID  <= 1'b0;
      pc_IFID     <= {XLEN{1'b0}};
      inst_IFID   <= NOP_INST;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      kill_r      <= kill_s;
      skid_pc_r   <= skid_pc_s;
      skid_inst_r <= skid_inst_s;
      valid_IFID  <= valid_s;
      pc_IFID     <= pc_ifid_s;
      inst_IFID   <= inst_ifid_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic drop_s;

  // A response or skid entry thrown away by a redirect or a pending kill.
  assign drop_s = redirect_valid
                ? (((state_r == S_WAIT) && imem.imem_rvalid) || (state_r == S_HOLD))
                : ((state_r == S_WAIT) && imem.imem_rvalid && kill_r);

  // Stall and discard counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_kill_cnt  <= 32'd0;
    end else begin
      if (!pc_enable) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (drop_s) begin
        perf_kill_cnt <= perf_kill_cnt + 32'd1;
      end else begin
        perf_kill_cnt <= perf_kill_cnt;
      end
    end
  end
`endif

endmodule
